// File: rtl/lcd_sequencer.sv
// LCD sequencer: power-up wait, four-command init ROM, then single host writes, each followed by an execution delay.
// One issue cycle after accept; host is held off (ready low) from issue until the delay ends, and a done watchdog bounds each wait.
module lcd_sequencer #(
    parameter int T_PWRUP = 750000,
    parameter int T_EXEC  = 2000,
    parameter int T_LONG  = 82000,
    parameter int TIMEOUT = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       ready,
    output logic       init_done,
    output logic       error,
    output logic       start,
    output logic       CS,
    output logic       RS,
    output logic [7:0] data,
    input  logic       done
);
    typedef enum logic [2:0] {
        PWRUP, INIT_ISSUE, INIT_WAIT, INIT_DELAY, IDLE, ISSUE, WAIT_DONE, DELAY
    } state_t;

    localparam logic [19:0] PWRUP_LAST = 20'(T_PWRUP - 1);
    localparam logic [19:0] EXEC_LOAD  = 20'(T_EXEC - 1);
    localparam logic [19:0] LONG_LOAD  = 20'(T_LONG - 1);
    localparam logic [19:0] WDOG_LAST  = 20'(TIMEOUT - 1);

    state_t      state_q;
    logic [19:0] cnt_q;
    logic [1:0]  idx_q;
    logic        init_done_q;
    logic        error_q;
    logic        start_q;
    logic        cs_q;
    logic        rs_q;
    logic [7:0]  data_q;
    logic        long_cmd;

    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // clear-display and return-home need the long execution delay
    assign long_cmd  = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
    assign ready     = (state_q == IDLE) && init_done_q;
    assign init_done = init_done_q;
    assign error     = error_q;
    assign start     = start_q;
    assign CS        = cs_q;
    assign RS        = rs_q;
    assign data      = data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PWRUP;
            cnt_q       <= 20'd0;
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
            start_q     <= 1'b0;
            cs_q        <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            case (state_q)
                PWRUP: begin
                    if (cnt_q == PWRUP_LAST) begin
                        state_q <= INIT_ISSUE;
                        cnt_q   <= 20'd0;
                        idx_q   <= 2'd0;
                        start_q <= 1'b1;
                        cs_q    <= 1'b1;
                        rs_q    <= 1'b0;
                        data_q  <= init_rom(2'd0);
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                INIT_ISSUE, ISSUE: begin
                    // the issue cycle already counts toward the watchdog
                    state_q <= (state_q == INIT_ISSUE) ? INIT_WAIT : WAIT_DONE;
                    start_q <= 1'b0;
                    cnt_q   <= 20'd1;
                end
                INIT_WAIT, WAIT_DONE: begin
                    if (done || (cnt_q == WDOG_LAST)) begin
                        state_q <= (state_q == INIT_WAIT) ? INIT_DELAY : DELAY;
                        cs_q    <= 1'b0;
                        cnt_q   <= (done && !long_cmd) ? EXEC_LOAD : LONG_LOAD;
                        if (!done) begin
                            error_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                INIT_DELAY: begin
                    if (cnt_q != 20'd0) begin
                        cnt_q <= cnt_q - 20'd1;
                    end else if (idx_q != 2'd3) begin
                        state_q <= INIT_ISSUE;
                        idx_q   <= idx_q + 2'd1;
                        start_q <= 1'b1;
                        cs_q    <= 1'b1;
                        data_q  <= init_rom(idx_q + 2'd1);
                    end else begin
                        state_q     <= IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                DELAY: begin
                    if (cnt_q != 20'd0) begin
                        cnt_q <= cnt_q - 20'd1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    if (in_valid && ready) begin
                        state_q <= ISSUE;
                        start_q <= 1'b1;
                        cs_q    <= 1'b1;
                        rs_q    <= in_rs;
                        data_q  <= in_data;
                    end
                end
                default: state_q <= PWRUP;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: timeline reference model compared every cycle, plus literal timing/data pins.
module tb_lcd_sequencer;
    localparam int T_PWRUP  = 100;
    localparam int T_EXEC   = 20;
    localparam int T_LONG   = 50;
    localparam int TIMEOUT  = 63;
    localparam int DONE_LAT = 15;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_rs    = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       done     = 1'b0;
    logic       ready, init_done, error, start, CS, RS;
    logic [7:0] data;

    lcd_sequencer #(
        .T_PWRUP(T_PWRUP), .T_EXEC(T_EXEC), .T_LONG(T_LONG), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_rs(in_rs), .in_data(in_data),
        .ready(ready), .init_done(init_done), .error(error), .start(start), .CS(CS),
        .RS(RS), .data(data), .done(done)
    );

    always #5 clk = ~clk;

    int pin_checks = 0, pin_errors = 0, cmp_checks = 0, cmp_errors = 0;
    bit suppress = 1'b0, stray = 1'b0;
    int due = 0;

    // Downstream bus-cycle controller: done pulse DONE_LAT cycles after start.
    always @(posedge clk) begin
        #2;
        done = 1'b0;
        if (!reset) begin
            due = 0;
        end else begin
            if (due > 0) begin
                due = due - 1;
                if (due == 0) done = 1'b1;
            end
            if (start && !suppress) due = DONE_LAT;
            if (stray) done = 1'b1;
        end
    end

    // Reference model as a timeline: t counts cycles since reset release,
    // an operation occupies [op_s, end of wait], and nothing new happens before free_t.
    int         t = 0, free_t = T_PWRUP, op_s = -1, prev_t = 0;
    bit         waiting = 1'b0, m_init_done = 1'b0, m_error = 1'b0, prev_ready = 1'b0;
    logic       m_rs = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] init_q[$];

    function automatic bit long_cmd(input logic rs, input logic [7:0] d);
        return !rs && (d >= 8'd1) && (d <= 8'd3);
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            t = 0; free_t = T_PWRUP; op_s = -1; waiting = 1'b0;
            m_init_done = 1'b0; m_error = 1'b0; m_rs = 1'b0; m_data = 8'h00;
            init_q.delete();
            init_q.push_back(8'h38); init_q.push_back(8'h0C);
            init_q.push_back(8'h01); init_q.push_back(8'h06);
        end else begin
            prev_ready = m_init_done && !waiting && (t >= free_t);
            prev_t = t;
            t = t + 1;
            if (waiting && (prev_t > op_s) && done) begin
                waiting = 1'b0;
                free_t = t + (long_cmd(m_rs, m_data) ? T_LONG : T_EXEC);
            end else if (waiting && (prev_t == op_s + TIMEOUT - 1)) begin
                waiting = 1'b0;
                m_error = 1'b1;
                free_t = t + T_LONG;
            end else if (!waiting && (t == free_t) && (init_q.size() != 0)) begin
                m_rs = 1'b0; m_data = init_q.pop_front(); op_s = t; waiting = 1'b1;
            end else if (!waiting && (t == free_t) && !m_init_done) begin
                m_init_done = 1'b1;
            end else if (prev_ready && in_valid) begin
                m_rs = in_rs; m_data = in_data; op_s = t; waiting = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [13:0] got, want;
        got = {start, CS, RS, data, ready, init_done, error};
        if (!reset) want = '0;
        else want = {waiting && (t == op_s), waiting, m_rs, m_data,
                     m_init_done && !waiting && (t >= free_t), m_init_done, m_error};
        cmp_checks++;
        if (got !== want) begin
            cmp_errors++;
            $display("FAIL cycle_model t=%0d got=%h want=%h", t, got, want);
        end
    end

    task automatic pin(input string name, input int got, input int want);
        pin_checks++;
        if (got != want) begin
            pin_errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic run_init(input bit hold, input string tag);
        int st_t[$];
        int st_d[$];
        int id_t = -1;
        int want_t[4] = '{100, 136, 172, 238};
        int want_d[4] = '{'h38, 'h0C, 'h01, 'h06};
        in_valid = hold; in_rs = 1'b1; in_data = 8'h41;
        @(negedge clk);
        pin({tag, "_reset_outputs"}, int'({start, CS, RS, data, ready, init_done, error}), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (start) begin st_t.push_back(i); st_d.push_back(int'(data)); end
            if (init_done && (id_t < 0)) id_t = i;
        end
        in_valid = 1'b0;
        pin({tag, "_start_count"}, st_t.size(), hold ? 5 : 4);
        if (st_t.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                pin($sformatf("%s_start%0d_cycle", tag, k), st_t[k], want_t[k]);
                pin($sformatf("%s_start%0d_data", tag, k), st_d[k], want_d[k]);
            end
        end
        pin({tag, "_init_done_cycle"}, id_t, 274);
        if (hold && (st_t.size() == 5)) pin({tag, "_held_accept_start"}, st_t[4], 275);
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        @(negedge clk);
        while (!start && (n < 400)) begin @(negedge clk); n++; end
        pin({tag, "_start_seen"}, int'(start), 1);
    endtask

    task automatic do_write(input logic rs, input logic [7:0] d, input int want_gap, input string tag);
        int n = 0;
        int gap = 0;
        bit stable = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_rs = rs; in_data = d;
        @(negedge clk);
        while (!ready && (n < 400)) begin @(negedge clk); n++; end
        if (!ready) begin
            pin({tag, "_ready_timeout"}, 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_rs = ~rs; in_data = ~d;
        @(negedge clk);
        pin({tag, "_start_after_accept"}, int'(start), 1);
        pin({tag, "_rs_data"}, int'({RS, data}), int'({rs, d}));
        n = 0;
        while (!done && (n < 100)) begin
            @(negedge clk); n++;
            if ((RS !== rs) || (data !== d)) stable = 1'b0;
        end
        if (!done) begin
            pin({tag, "_done_timeout"}, 0, 1);
            return;
        end
        @(negedge clk);
        while (!ready && (gap < 200)) begin
            if ((RS !== rs) || (data !== d)) stable = 1'b0;
            gap++;
            @(negedge clk);
        end
        pin({tag, "_not_ready_cycles"}, gap, want_gap);
        pin({tag, "_rs_data_stable"}, int'(stable), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int n;
        int gap;
        int hs[$];

        run_init(1'b0, "init");
        pin("error_after_init", int'(error), 0);
        pin("ready_after_init", int'(ready), 1);

        do_write(1'b1, 8'h41, T_EXEC, "w41");
        do_write(1'b0, 8'h02, T_LONG, "w02");
        do_write(1'b0, 8'h01, T_LONG, "w01");
        do_write(1'b0, 8'h80, T_EXEC, "w80");
        do_write(1'b0, 8'h00, T_EXEC, "w00");

        // Continuous request: exactly one accept per IDLE entry.
        in_rs = 1'b1; in_data = 8'h41;
        @(posedge clk); #1;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (start) hs.push_back(i);
        end
        in_valid = 1'b0;
        pin("hold_enough_starts", int'(hs.size() >= 5), 1);
        for (int i = 1; i < hs.size(); i++) pin($sformatf("hold_spacing%0d", i), hs[i] - hs[i-1], 37);

        for (int k = 0; k < 12; k++) begin
            logic       r;
            logic [7:0] d;
            r = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 4)) @(posedge clk);
            do_write(r, d, long_cmd(r, d) ? T_LONG : T_EXEC, $sformatf("rnd%0d", k));
        end

        // Watchdog: controller never answers.
        suppress = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h55;
        wait_start("wdog");
        in_valid = 1'b0;
        n = 0;
        while (!error && (n < 200)) begin @(negedge clk); n++; end
        pin("wdog_error_latency", n, TIMEOUT);
        pin("wdog_cs_dropped", int'(CS), 0);
        gap = 0;
        while (!ready && (gap < 200)) begin gap++; @(negedge clk); end
        pin("wdog_not_ready_cycles", gap, T_LONG);
        suppress = 1'b0;

        // Stray done while idle.
        @(posedge clk); #1; stray = 1'b1;
        @(posedge clk); #1; stray = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (start) n++; end
        pin("stray_no_start", n, 0);
        pin("stray_ready", int'(ready), 1);

        do_write(1'b1, 8'h42, T_EXEC, "post_wdog");
        pin("error_sticky", int'(error), 1);

        // Reset while waiting for done.
        @(posedge clk); #1;
        in_valid = 1'b1; in_rs = 1'b0; in_data = 8'h01;
        wait_start("rst_wait");
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        pin("rst_wait_cs_before", int'(CS), 1);
        @(posedge clk); #1; reset = 1'b0; #1;
        pin("rst_wait_outputs", int'({start, CS, RS, data, ready, init_done, error}), 0);
        repeat (3) @(negedge clk);
        run_init(1'b1, "reinit_hold");

        // Reset during the post-write delay.
        @(posedge clk); #1;
        in_valid = 1'b1; in_rs = 1'b0; in_data = 8'h02;
        wait_start("rst_delay");
        in_valid = 1'b0;
        n = 0;
        while (!done && (n < 100)) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        pin("rst_delay_in_delay", int'({CS, ready}), 0);
        @(posedge clk); #1; reset = 1'b0; #1;
        pin("rst_delay_outputs", int'({start, CS, RS, data, ready, init_done, error}), 0);
        repeat (3) @(negedge clk);
        run_init(1'b0, "reinit");

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", cmp_errors + pin_errors, cmp_checks + pin_checks);
        $finish;
    end
endmodule
